// File: rtl/modular_alu_issuer.sv
// rtl/modular_alu_issuer.sv - command FIFO, operand screen and settle timer in front of the modular ALU
module modular_alu_issuer #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 4,
    parameter int TAG_W      = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [3:0]                 cmd_op,
    input  logic [WIDTH-1:0]           cmd_a,
    input  logic [WIDTH-1:0]           cmd_b,
    input  logic [WIDTH-1:0]           cmd_m,
    input  logic [TAG_W-1:0]           cmd_tag,
    output logic [3:0]                 alu_op,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    output logic [WIDTH-1:0]           alu_m,
    input  logic [WIDTH-1:0]           alu_r,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WIDTH-1:0]           rsp_data,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic                       rsp_err,
    output logic [$clog2(DEPTH):0]     fifo_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 4 + 3 * WIDTH + TAG_W;
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d, data_q, data_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             err_q, err_d;

    logic             push, pop, head_err;
    logic [3:0]       h_op;
    logic [WIDTH-1:0] h_a, h_b, h_m;
    logic [TAG_W-1:0] h_tag;

    assign cmd_ready  = (count_q < CNT_W'(DEPTH));
    assign push       = cmd_valid & cmd_ready;
    assign fifo_count = count_q;

    assign {h_op, h_a, h_b, h_m, h_tag} = mem_q[rd_ptr_q];

    // Screen: modular ops need M!=0, A%B and div need B!=0, C..F undefined
    always_comb begin
        head_err = 1'b0;
        if (h_op >= 4'hC)
            head_err = 1'b1;
        if ((h_op == 4'd0 || h_op == 4'd1 || h_op == 4'd2 || h_op == 4'd4 || h_op == 4'd5)
            && h_m == '0)
            head_err = 1'b1;
        if ((h_op == 4'd3 || h_op == 4'd4) && h_b == '0)
            head_err = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b, cmd_m, cmd_tag};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)
                count_q <= count_q + CNT_W'(1);
            else if (pop && !push)
                count_q <= count_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        tag_d   = tag_q;
        data_d  = data_q;
        err_d   = err_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop   = 1'b1;
                    op_d  = h_op;
                    a_d   = h_a;
                    b_d   = h_b;
                    m_d   = h_m;
                    tag_d = h_tag;
                    if (head_err) begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = SETTLE_LD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    data_d  = alu_r;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            tag_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_m     = m_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = data_q;
    assign rsp_tag   = tag_q;
    assign rsp_err   = err_q;
endmodule
